pwm_load_sched: RTL and testbench

Period-aligned update controller for the shared PWM output stage. It arbitrates sample updates from N_REQ requesters, such as the effects chain and a volume/test source, using round-robin valid/ready handshakes. It holds one pending sample and issues the PWM `load` pulse only in the last cycle of a PWM period, so duty changes never split a period. It also owns the PWM `max` configuration and applies new values on the same period boundary.

---
 rtl/pwm_pkg.sv | 9 +
 rtl/pwm_load_sched_rr_arbiter.sv | 30 +++
 rtl/pwm_load_sched.sv | 117 +++++++++++
 tb/tb_pwm_load_sched.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/pwm_pkg.sv
// Shared defaults and types for the PWM output stage and its update controller.
package pwm_pkg;

    localparam int DEF_WIDTH   = 10;
    localparam int DEF_MAX_RST = 1023;

    typedef logic [DEF_WIDTH-1:0] sample_t;

endpackage

// File: rtl/pwm_load_sched_rr_arbiter.sv
// Stateless round-robin arbiter: grants the first requester at or after ptr.
module rr_arbiter #(
    parameter int N_REQ = 2,
    parameter int PTR_W = 1
) (
    input  logic [N_REQ-1:0] req,
    input  logic [PTR_W-1:0] ptr,
    output logic [N_REQ-1:0] grant
);

    int   idx;
    logic found;

    always_comb begin
        grant = '0;
        found = 1'b0;
        idx   = 0;
        for (int k = 0; k < N_REQ; k++) begin
            idx = int'(ptr) + k;
            if (idx >= N_REQ) begin
                idx = idx - N_REQ;
            end
            if (!found && req[idx]) begin
                grant[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/pwm_load_sched.sv
// Holds one pending PWM sample and a pending period maximum, releasing both
// only on the last cycle of a PWM period so no period is ever split.
module pwm_load_sched
    import pwm_pkg::*;
#(
    parameter int WIDTH   = DEF_WIDTH,
    parameter int N_REQ   = 2,
    parameter int MAX_RST = DEF_MAX_RST
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [N_REQ-1:0]       req_valid,
    input  logic [N_REQ*WIDTH-1:0] req_data,
    output logic [N_REQ-1:0]       req_ready,
    input  logic [WIDTH-1:0]       cfg_max,
    input  logic                   cfg_max_we,
    output logic                   pwm_load,
    output logic [WIDTH-1:0]       pwm_data,
    output logic [WIDTH-1:0]       max_out,
    output logic                   period_end
);

    localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    logic [WIDTH-1:0] cnt_reg;
    logic [WIDTH-1:0] max_out_reg;
    logic [WIDTH-1:0] max_pend_reg;
    logic             max_pend_valid_reg;
    logic [WIDTH-1:0] pend_data_reg;
    logic             pend_valid_reg;
    logic [PTR_W-1:0] rr_reg;

    logic [WIDTH-1:0] req_word [N_REQ];
    logic [N_REQ-1:0] grant;
    logic [PTR_W-1:0] gnt_idx;
    logic [WIDTH-1:0] gnt_data;
    logic [PTR_W-1:0] rr_next;
    logic [WIDTH-1:0] max_next;
    logic [WIDTH-1:0] load_src;
    logic             boundary;
    logic             slot_free;
    logic             xfer;

    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_unpack
        assign req_word[gi] = req_data[gi*WIDTH +: WIDTH];
    end

    rr_arbiter #(
        .N_REQ (N_REQ),
        .PTR_W (PTR_W)
    ) u_arb (
        .req   (req_valid),
        .ptr   (rr_reg),
        .grant (grant)
    );

    always_comb begin
        gnt_idx  = '0;
        gnt_data = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (grant[i]) begin
                gnt_idx  = PTR_W'(i);
                gnt_data = req_word[i];
            end
        end
    end

    assign rr_next   = (gnt_idx == PTR_W'(N_REQ - 1)) ? '0 : gnt_idx + 1'b1;
    assign boundary  = (cnt_reg == max_out_reg);
    // The slot can accept while it is being drained on a boundary.
    assign slot_free = !pend_valid_reg || boundary;
    assign req_ready = (rst_n && slot_free) ? grant : '0;
    assign xfer      = |req_ready;

    assign max_next  = cfg_max_we         ? cfg_max      :
                       max_pend_valid_reg ? max_pend_reg : max_out_reg;

    // An empty slot on a boundary passes a fresh sample straight through.
    assign load_src   = pend_valid_reg ? pend_data_reg : gnt_data;
    assign pwm_load   = rst_n && boundary && (pend_valid_reg || xfer);
    assign pwm_data   = !pwm_load            ? '0       :
                        (load_src > max_next) ? max_next : load_src;
    assign period_end = rst_n && boundary;
    assign max_out    = max_out_reg;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_reg            <= '0;
            max_out_reg        <= WIDTH'(MAX_RST);
            max_pend_reg       <= '0;
            max_pend_valid_reg <= 1'b0;
            pend_data_reg      <= '0;
            pend_valid_reg     <= 1'b0;
            rr_reg             <= '0;
        end else begin
            cnt_reg <= boundary ? '0 : cnt_reg + 1'b1;

            if (boundary) begin
                max_out_reg        <= max_next;
                max_pend_valid_reg <= 1'b0;
            end else if (cfg_max_we) begin
                max_pend_reg       <= cfg_max;
                max_pend_valid_reg <= 1'b1;
            end

            if (xfer) begin
                pend_data_reg <= gnt_data;
                rr_reg        <= rr_next;
            end

            // On a boundary the slot survives only if refilled after draining.
            pend_valid_reg <= boundary ? (pend_valid_reg && xfer)
                                       : (pend_valid_reg || xfer);
        end
    end

endmodule

// File: tb/tb_pwm_load_sched.sv
// Randomised scoreboard bench for pwm_load_sched against a queue-based model.
module tb_pwm_load_sched;

    localparam int W       = 10;
    localparam int N       = 2;
    localparam int MAX_RST = 9;
    localparam int CYCLES  = 4000;

    logic             clk;
    logic             rst_n;
    logic [N-1:0]     req_valid;
    logic [N*W-1:0]   req_data;
    logic [N-1:0]     req_ready;
    logic [W-1:0]     cfg_max;
    logic             cfg_max_we;
    logic             pwm_load;
    logic [W-1:0]     pwm_data;
    logic [W-1:0]     max_out;
    logic             period_end;

    pwm_load_sched #(
        .WIDTH   (W),
        .N_REQ   (N),
        .MAX_RST (MAX_RST)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_data   (req_data),
        .req_ready  (req_ready),
        .cfg_max    (cfg_max),
        .cfg_max_we (cfg_max_we),
        .pwm_load   (pwm_load),
        .pwm_data   (pwm_data),
        .max_out    (max_out),
        .period_end (period_end)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int n_loads  = 0;

    // Requester sample queues (front = currently offered sample)
    int src_q [N][$];
    // Expected load values, pushed by the model, popped by the monitor
    int exp_q [$];

    // Reference model state
    int m_pos, m_max, m_pmax, m_pmax_v, m_rr, m_grant;
    int m_slot [$];

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int imin(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    // Model: evaluates the period/slot rules each cycle on the falling edge
    always @(negedge clk) begin
        int bnd, nm, g, took, idx, gdata;
        if (!rst_n) begin
            check("ready_rst", int'(req_ready), 0);
            check("period_end_rst", int'(period_end), 0);
            check("load_rst", int'(pwm_load), 0);
            check("data_rst", int'(pwm_data), 0);
            m_pos = 0; m_max = MAX_RST; m_pmax = 0; m_pmax_v = 0;
            m_rr = 0; m_grant = -1;
            m_slot.delete();
        end else begin
            bnd = (m_pos == m_max) ? 1 : 0;
            nm  = cfg_max_we ? int'(cfg_max) : (m_pmax_v != 0 ? m_pmax : m_max);
            g = -1;
            if (m_slot.size() == 0 || bnd != 0) begin
                for (int k = 0; k < N; k++) begin
                    idx = (m_rr + k) % N;
                    if (g < 0 && req_valid[idx]) g = idx;
                end
            end
            gdata = (g >= 0) ? src_q[g][0] : 0;
            check("req_ready", int'(req_ready), (g >= 0) ? (1 << g) : 0);
            check("period_end", int'(period_end), bnd);
            check("max_out", int'(max_out), m_max);
            took = 0;
            if (bnd != 0) begin
                if (m_slot.size() > 0) begin
                    exp_q.push_back(imin(m_slot.pop_front(), nm));
                end else if (g >= 0) begin
                    exp_q.push_back(imin(gdata, nm));
                    took = 1;
                end
            end
            if (g >= 0 && took == 0) m_slot.push_back(gdata);
            if (bnd != 0) begin
                m_pos = 0; m_max = nm; m_pmax_v = 0;
            end else begin
                m_pos++;
                if (cfg_max_we) begin m_pmax = int'(cfg_max); m_pmax_v = 1; end
            end
            if (g >= 0) m_rr = (g + 1) % N;
            m_grant = g;
        end
    end

    // Monitor: pops the scoreboard whenever the DUT presents a load
    always @(negedge clk) begin
        int e;
        #1;
        if (pwm_load) begin
            n_checks++;
            n_loads++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL load_unexpected: got load data %0d, expected no load at %0t",
                         pwm_data, $time);
            end else begin
                e = exp_q.pop_front();
                n_checks--;
                check("pwm_data", int'(pwm_data), e);
            end
        end else if (exp_q.size() > 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL load_missing: got no load, expected data %0d at %0t",
                     exp_q[0], $time);
            exp_q.delete();
        end
    end

    task automatic drive_reqs();
        for (int i = 0; i < N; i++) begin
            req_valid[i] = (src_q[i].size() > 0);
            req_data[i*W +: W] = (src_q[i].size() > 0) ? W'(src_q[i][0]) : '0;
        end
    endtask

    initial begin
        rst_n      = 1'b0;
        req_valid  = '0;
        req_data   = '0;
        cfg_max    = '0;
        cfg_max_we = 1'b0;
        m_grant    = -1;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        for (int c = 0; c < CYCLES; c++) begin
            @(posedge clk);
            #1;
            if (m_grant >= 0) void'(src_q[m_grant].pop_front());
            m_grant = -1;
            rst_n = !(c >= 2000 && c < 2004);
            if (c == 1995) begin
                // Pending sample and pending max right before reset
                src_q[0].push_back(300);
                cfg_max    = 10'd6;
                cfg_max_we = 1'b1;
            end else if (c >= 40) begin
                for (int i = 0; i < N; i++) begin
                    if (src_q[i].size() < 3 && $urandom_range(0, 5) == 0)
                        src_q[i].push_back(int'($urandom_range(0, 1023)));
                end
                cfg_max_we = ($urandom_range(0, 29) == 0);
                cfg_max    = ($urandom_range(0, 7) == 0) ? 10'd0
                                                         : W'($urandom_range(1, 14));
            end else begin
                cfg_max_we = 1'b0;
            end
            drive_reqs();
        end
        @(posedge clk);
        #1;
        req_valid  = '0;
        cfg_max_we = 1'b0;
        repeat (3) @(negedge clk);
        #2;
        n_checks++;
        if (n_loads < 50) begin
            n_fail++;
            $display("FAIL load_count: got %0d loads, expected at least 50", n_loads);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
